// File: rtl/alt_vipvfr130_pwc_core.sv
// Packet write controller: takes one Avalon-ST video packet per GO, issues a
// single write command, streams samples to the write master and reports the result.
module alt_vipvfr130_pwc_core #(
    parameter int BITS_PER_SYMBOL              = 8,
    parameter int SYMBOLS_PER_BEAT             = 3,
    parameter int BURST_LENGTH_REQUIREDWIDTH   = 7,
    parameter int PACKET_SAMPLES_REQUIREDWIDTH = 32
) (
    input  logic                                         clock,
    input  logic                                         reset,
    output logic                                         ready_in,
    input  logic                                         valid_in,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  data_in,
    input  logic                                         sop_in,
    input  logic                                         eop_in,
    input  logic                                         master_stall,
    output logic                                         cmd,
    output logic [31:0]                                  cmd_addr,
    output logic [BURST_LENGTH_REQUIREDWIDTH-1:0]        cmd_length_of_burst,
    output logic                                         write,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  wdata,
    output logic                                         flush_partial_word,
    input  logic                                         enable,
    output logic                                         clear_enable,
    input  logic [31:0]                                  packet_addr,
    input  logic [BURST_LENGTH_REQUIREDWIDTH-1:0]        packet_words,
    input  logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0]      packet_max_samples,
    output logic                                         stopped,
    output logic                                         complete,
    output logic [3:0]                                   packet_type_out,
    output logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0]      packet_samples_out,
    output logic                                         truncated
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOP,
        WRITING,
        DISCARD,
        ENDING
    } state_t;

    state_t                                    state;
    logic [31:0]                               addr_q;
    logic [BURST_LENGTH_REQUIREDWIDTH-1:0]     words_q;
    logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0]   max_q;
    logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0]   count;
    logic                                      accept;
    logic                                      room;

    // The sink is throttled directly by the master, so ready/write are combinational.
    always_comb begin
        ready_in = 1'b0;
        case (state)
            WAIT_SOP, DISCARD: ready_in = 1'b1;
            WRITING:           ready_in = !cmd && !master_stall;
            default:           ready_in = 1'b0;
        endcase
        accept = valid_in && ready_in;
        room   = count < max_q;
        write  = (state == WRITING) && accept && !sop_in && room;
        wdata  = data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            clear_enable        <= 1'b1;
            stopped             <= 1'b1;
            cmd                 <= 1'b0;
            cmd_addr            <= '0;
            cmd_length_of_burst <= '0;
            flush_partial_word  <= 1'b0;
            complete            <= 1'b0;
            truncated           <= 1'b0;
            count               <= '0;
            packet_type_out     <= '0;
            packet_samples_out  <= '0;
            addr_q              <= '0;
            words_q             <= '0;
            max_q               <= '0;
        end else begin
            clear_enable <= 1'b0;
            complete     <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        clear_enable <= 1'b1;
                        addr_q       <= packet_addr;
                        words_q      <= packet_words;
                        max_q        <= packet_max_samples;
                        stopped      <= 1'b0;
                        count        <= '0;
                        truncated    <= 1'b0;
                        state        <= WAIT_SOP;
                    end
                end
                WAIT_SOP: begin
                    if (accept && sop_in) begin
                        packet_type_out     <= data_in[3:0];
                        cmd                 <= 1'b1;
                        cmd_addr            <= addr_q;
                        cmd_length_of_burst <= words_q;
                        state               <= WRITING;
                    end
                end
                WRITING: begin
                    if (cmd && !master_stall)
                        cmd <= 1'b0;
                    if (accept) begin
                        // A fresh sop ends the current packet early; its beat is not written.
                        if (sop_in) begin
                            flush_partial_word <= 1'b1;
                            truncated          <= 1'b1;
                            state              <= ENDING;
                        end else if (room || eop_in) begin
                            if (room)
                                count <= count + 1'b1;
                            if (eop_in) begin
                                flush_partial_word <= 1'b1;
                                state              <= ENDING;
                            end
                        end else begin
                            truncated <= 1'b1;
                            state     <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (accept && eop_in) begin
                        flush_partial_word <= 1'b1;
                        state              <= ENDING;
                    end
                end
                ENDING: begin
                    if (flush_partial_word) begin
                        if (!master_stall)
                            flush_partial_word <= 1'b0;
                    end else begin
                        packet_samples_out <= count;
                        complete           <= 1'b1;
                        stopped            <= 1'b1;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alt_vipvfr130_pwc_core.sv
// Directed bench for alt_vipvfr130_pwc_core: a cycle table for a normal packet
// plus hand-written sequences for truncation, stalls, stray beats and reset.
module tb_alt_vipvfr130_pwc_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ready_in;
    logic        valid_in = 1'b0;
    logic [23:0] data_in = '0;
    logic        sop_in = 1'b0;
    logic        eop_in = 1'b0;
    logic        master_stall = 1'b0;
    logic        cmd;
    logic [31:0] cmd_addr;
    logic [6:0]  cmd_length_of_burst;
    logic        write;
    logic [23:0] wdata;
    logic        flush_partial_word;
    logic        enable = 1'b0;
    logic        clear_enable;
    logic [31:0] packet_addr = 32'h1000;
    logic [6:0]  packet_words = 7'd2;
    logic [31:0] packet_max_samples = 32'd4;
    logic        stopped;
    logic        complete;
    logic [3:0]  packet_type_out;
    logic [31:0] packet_samples_out;
    logic        truncated;

    alt_vipvfr130_pwc_core #(
        .BITS_PER_SYMBOL(8),
        .SYMBOLS_PER_BEAT(3),
        .BURST_LENGTH_REQUIREDWIDTH(7),
        .PACKET_SAMPLES_REQUIREDWIDTH(32)
    ) dut (
        .clock(clock), .reset(reset), .ready_in(ready_in), .valid_in(valid_in),
        .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in), .master_stall(master_stall),
        .cmd(cmd), .cmd_addr(cmd_addr), .cmd_length_of_burst(cmd_length_of_burst),
        .write(write), .wdata(wdata), .flush_partial_word(flush_partial_word),
        .enable(enable), .clear_enable(clear_enable), .packet_addr(packet_addr),
        .packet_words(packet_words), .packet_max_samples(packet_max_samples),
        .stopped(stopped), .complete(complete), .packet_type_out(packet_type_out),
        .packet_samples_out(packet_samples_out), .truncated(truncated)
    );

    always #5 clock = ~clock;

    int     checks = 0;
    int     errors = 0;
    int     n_write = 0;
    int     n_cmd = 0;
    int     n_cmp = 0;
    longint wsum = 0;

    // Inputs change at posedge+2; everything is observed on the falling edge.
    always @(negedge clock) begin
        if (write === 1'b1) begin
            n_write++;
            wsum += longint'(wdata);
        end
        if (cmd === 1'b1 && master_stall == 1'b0) n_cmd++;
        if (complete === 1'b1) n_cmp++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, en, vl, sop, eop, stall;
        logic [23:0] data;
        logic        rdy, wr, cm, fl, cp, sp, cl;
    } vec_t;

    function automatic vec_t mk(input logic rst, en, vl, sop, eop, stall,
                                input logic [23:0] data,
                                input logic rdy, wr, cm, fl, cp, sp, cl);
        vec_t r;
        r.rst = rst; r.en = en; r.vl = vl; r.sop = sop; r.eop = eop; r.stall = stall;
        r.data = data;
        r.rdy = rdy; r.wr = wr; r.cm = cm; r.fl = fl; r.cp = cp; r.sp = sp; r.cl = cl;
        return r;
    endfunction

    task automatic start(input logic [31:0] a, input logic [6:0] w, input logic [31:0] m);
        packet_addr = a; packet_words = w; packet_max_samples = m;
        enable = 1'b1;
        @(posedge clock); #2;
        enable = 1'b0;
        @(negedge clock);
        check("start_clear_enable", clear_enable, 1);
        check("start_stopped", stopped, 0);
        @(posedge clock); #2;
    endtask

    task automatic send(input logic s, input logic e, input logic [23:0] d);
        int n = 0;
        valid_in = 1'b1; sop_in = s; eop_in = e; data_in = d;
        @(negedge clock);
        while (ready_in !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (ready_in !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=ready_low required=accept data=%0h", d);
        end
        @(posedge clock); #2;
        valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    endtask

    task automatic wait_complete(input string name);
        int n = 0;
        @(negedge clock);
        while (complete !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({name, "_complete"}, complete, 1);
        @(negedge clock);
        check({name, "_complete_one_cycle"}, complete, 0);
        check({name, "_stopped"}, stopped, 1);
        @(posedge clock); #2;
    endtask

    vec_t tbl [13];

    initial begin
        int w0, c0, p0;
        longint s0;

        tbl[0]  = mk(1,0,0,0,0,0, 24'h0,      0,0,0,0,0,1,1);
        tbl[1]  = mk(0,0,0,0,0,0, 24'h0,      0,0,0,0,0,1,1);
        tbl[2]  = mk(0,1,0,0,0,0, 24'h0,      0,0,0,0,0,1,0);
        tbl[3]  = mk(0,0,1,1,0,0, 24'h0,      1,0,0,0,0,0,1);
        tbl[4]  = mk(0,0,1,0,0,0, 24'hABCDA1, 0,0,1,0,0,0,0);
        tbl[5]  = mk(0,0,1,0,0,0, 24'hABCDA1, 1,1,0,0,0,0,0);
        tbl[6]  = mk(0,0,1,0,0,0, 24'hABCDA2, 1,1,0,0,0,0,0);
        tbl[7]  = mk(0,0,1,0,0,0, 24'hABCDA3, 1,1,0,0,0,0,0);
        tbl[8]  = mk(0,0,1,0,1,0, 24'hABCDA4, 1,1,0,0,0,0,0);
        tbl[9]  = mk(0,0,0,0,0,0, 24'h0,      0,0,0,1,0,0,0);
        tbl[10] = mk(0,0,0,0,0,0, 24'h0,      0,0,0,0,0,0,0);
        tbl[11] = mk(0,0,0,0,0,0, 24'h0,      0,0,0,0,1,1,0);
        tbl[12] = mk(0,0,0,0,0,0, 24'h0,      0,0,0,0,0,1,0);

        repeat (2) @(posedge clock);
        #2;
        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; enable = tbl[i].en; valid_in = tbl[i].vl;
            sop_in = tbl[i].sop; eop_in = tbl[i].eop; master_stall = tbl[i].stall;
            data_in = tbl[i].data;
            @(negedge clock);
            check($sformatf("t%0d_ready", i), ready_in, tbl[i].rdy);
            check($sformatf("t%0d_write", i), write, tbl[i].wr);
            check($sformatf("t%0d_cmd", i), cmd, tbl[i].cm);
            check($sformatf("t%0d_flush", i), flush_partial_word, tbl[i].fl);
            check($sformatf("t%0d_complete", i), complete, tbl[i].cp);
            check($sformatf("t%0d_stopped", i), stopped, tbl[i].sp);
            check($sformatf("t%0d_clear_enable", i), clear_enable, tbl[i].cl);
            if (tbl[i].wr) check($sformatf("t%0d_wdata", i), wdata, tbl[i].data);
            @(posedge clock); #2;
        end
        valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
        check("t_cmd_addr", cmd_addr, 32'h1000);
        check("t_cmd_len", cmd_length_of_burst, 2);
        check("t_samples_out", packet_samples_out, 4);
        check("t_truncated", truncated, 0);
        check("t_type", packet_type_out, 0);
        check("t_writes", n_write, 4);
        check("t_cmds", n_cmd, 1);

        // Over-length packet: max 3, six data beats.
        w0 = n_write; s0 = wsum;
        start(32'h2000, 7'd5, 32'd3);
        send(1, 0, 24'h5);
        for (int k = 1; k <= 6; k++) send(0, (k == 6), 24'(k));
        wait_complete("trunc");
        check("trunc_writes", n_write - w0, 3);
        check("trunc_wsum", wsum - s0, 6);
        check("trunc_samples_out", packet_samples_out, 3);
        check("trunc_flag", truncated, 1);
        check("trunc_type", packet_type_out, 5);

        // Master stalls while the command is pending and mid-stream.
        w0 = n_write; s0 = wsum; c0 = n_cmd;
        start(32'h3000, 7'd4, 32'd4);
        valid_in = 1'b1; sop_in = 1'b1; data_in = 24'h2; master_stall = 1'b1;
        @(negedge clock);
        @(posedge clock); #2;
        valid_in = 1'b0; sop_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("stall_cmd_held%0d", k), cmd, 1);
            check($sformatf("stall_cmd_ready%0d", k), ready_in, 0);
            @(posedge clock); #2;
        end
        master_stall = 1'b0;
        send(0, 0, 24'h10);
        send(0, 0, 24'h11);
        valid_in = 1'b1; data_in = 24'h12; master_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("stall_mid_ready%0d", k), ready_in, 0);
            check($sformatf("stall_mid_write%0d", k), write, 0);
            @(posedge clock); #2;
        end
        master_stall = 1'b0;
        send(0, 0, 24'h12);
        send(0, 1, 24'h13);
        wait_complete("stall");
        check("stall_writes", n_write - w0, 4);
        check("stall_wsum", wsum - s0, 24'h10 + 24'h11 + 24'h12 + 24'h13);
        check("stall_cmds", n_cmd - c0, 1);
        check("stall_cmd_addr", cmd_addr, 32'h3000);
        check("stall_samples_out", packet_samples_out, 4);
        check("stall_truncated", truncated, 0);

        // Stray beats before the sop are ignored.
        w0 = n_write; s0 = wsum;
        start(32'h4000, 7'd2, 32'd4);
        send(0, 0, 24'hAA);
        send(0, 1, 24'hBB);
        send(1, 0, 24'h5F);
        send(0, 1, 24'h77);
        wait_complete("stray");
        check("stray_writes", n_write - w0, 1);
        check("stray_wsum", wsum - s0, 24'h77);
        check("stray_type", packet_type_out, 4'hF);
        check("stray_samples_out", packet_samples_out, 1);
        check("stray_cmd_addr", cmd_addr, 32'h4000);

        // Zero max: nothing is written, first data beat starts discarding.
        w0 = n_write;
        start(32'h6000, 7'd1, 32'd0);
        send(1, 0, 24'h4);
        send(0, 0, 24'h1);
        send(0, 1, 24'h2);
        wait_complete("zero");
        check("zero_writes", n_write - w0, 0);
        check("zero_samples_out", packet_samples_out, 0);
        check("zero_truncated", truncated, 1);

        // A new sop after two data beats terminates the packet.
        w0 = n_write; p0 = n_cmp;
        start(32'h5000, 7'd3, 32'd8);
        send(1, 0, 24'h3);
        send(0, 0, 24'h31);
        send(0, 0, 24'h32);
        send(1, 0, 24'h9);
        wait_complete("midsop");
        check("midsop_writes", n_write - w0, 2);
        check("midsop_samples_out", packet_samples_out, 2);
        check("midsop_truncated", truncated, 1);
        check("midsop_type", packet_type_out, 3);
        check("midsop_pulses", n_cmp - p0, 1);

        // Reset in the middle of a packet.
        p0 = n_cmp;
        start(32'h7000, 7'd3, 32'd8);
        send(1, 0, 24'h9);
        send(0, 0, 24'h21);
        reset = 1'b1; valid_in = 1'b1; data_in = 24'h22;
        @(posedge clock);
        @(negedge clock);
        check("rst_ready", ready_in, 0);
        check("rst_write", write, 0);
        check("rst_cmd", cmd, 0);
        check("rst_flush", flush_partial_word, 0);
        check("rst_complete", complete, 0);
        check("rst_stopped", stopped, 1);
        check("rst_clear_enable", clear_enable, 1);
        check("rst_truncated", truncated, 0);
        check("rst_type", packet_type_out, 0);
        check("rst_samples_out", packet_samples_out, 0);
        @(posedge clock); #2;
        reset = 1'b0; valid_in = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        check("rst_no_complete", n_cmp - p0, 0);
        check("rst_idle_stopped", stopped, 1);
        check("rst_idle_clear_enable", clear_enable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/alt_vipvfr130_pwc_core.md
ALT_VIPVFR130_PWC_CORE -- requirements
Module: alt_vipvfr130_pwc_core

Interface
REQ-001 Parameters SHALL be: BITS_PER_SYMBOL 8, bits per colour symbol; SYMBOLS_PER_BEAT 3, symbols per beat (DW = product); BURST_LENGTH_REQUIREDWIDTH 7, burst field width (BW); PACKET_SAMPLES_REQUIREDWIDTH 32, sample counter width (SW); ADDR_WIDTH fixed local 32.
REQ-002 clock  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ready_in/valid_in/data_in/sop_in/eop_in  out/in/in/in/in  1/1/DW/1/1  Avalon-ST video sink.
REQ-005 master_stall  in  1  write master cannot accept cmd or write this cycle.
REQ-006 cmd  out  1  issue write command; held until accepted (master_stall low).
REQ-007 cmd_addr / cmd_length_of_burst  out  32 / BW  command address and word count.
REQ-008 write / wdata  out  1 / DW  write one sample to master.
REQ-009 flush_partial_word  out  1  push final partially packed word to memory.
REQ-010 enable  in  1  GO bit; clear_enable  out  1  clears GO bit.
REQ-011 packet_addr / packet_words / packet_max_samples  in  32 / BW / SW  sampled at start.
REQ-012 stopped  out  1  STATUS, high when idle; complete  out  1  IRQ pulse.
REQ-013 packet_type_out / packet_samples_out / truncated  out  4 / SW / 1  result of last packet.

Function
REQ-014 States SHALL be IDLE, WAIT_SOP, WRITING, DISCARD, ENDING.
REQ-015 IDLE: enable high -> clear_enable=1 for one cycle, capture packet_addr/packet_words/packet_max_samples, stopped=0, samples counter=0, truncated=0, go WAIT_SOP; else hold.
REQ-016 ready_in SHALL be 1 in WAIT_SOP and DISCARD; in WRITING equal to !cmd & !master_stall; 0 in IDLE and ENDING.
REQ-017 A beat is accepted when valid_in & ready_in.
REQ-018 WAIT_SOP: accepted beat with sop_in=0 SHALL be dropped; with sop_in=1 SHALL set packet_type_out=data_in[3:0], assert cmd with cmd_addr=captured addr, cmd_length_of_burst=captured words, go WRITING.
REQ-019 cmd SHALL deassert the cycle after a cycle with cmd=1 and master_stall=0; no write issues while cmd=1.
REQ-020 WRITING: accepted beat with sop_in=0 and counter < max SHALL produce write=1, wdata=data_in same cycle (combinational), counter+1.
REQ-021 WRITING: accepted beat with eop_in=1 (after its write, if any) SHALL assert flush_partial_word next cycle and go ENDING.
REQ-022 WRITING: accepted beat when counter == max and eop_in=0 SHALL be dropped, set truncated=1, go DISCARD.
REQ-023 WRITING: accepted beat with sop_in=1 SHALL be dropped and terminate packet as eop (flush, ENDING, truncated=1).
REQ-024 DISCARD: drop all beats; accepted eop_in=1 -> flush, go ENDING.
REQ-025 flush_partial_word SHALL hold until a cycle with master_stall=0, then drop.
REQ-026 ENDING: when flush low, packet_samples_out=counter, complete=1 for exactly one cycle, stopped=1, go IDLE.
REQ-027 Counter SHALL saturate at max; packet_max_samples=0 SHALL write nothing and enter DISCARD on first data beat.
REQ-028 enable deassertion mid-packet SHALL NOT abort the packet; enable high in ENDING SHALL be honoured only once IDLE is reached.
REQ-029 write SHALL never assert outside WRITING; cmd only from WAIT_SOP -> WRITING.

Reset
REQ-030 reset SHALL force IDLE, clear_enable=1, stopped=1, ready_in=0, cmd=0, write=0, flush_partial_word=0, complete=0, truncated=0, counter=0, packet_type_out=0, packet_samples_out=0; clear_enable=0 first cycle after reset.
REQ-031 reset mid-packet SHALL abandon the packet with no complete pulse; reset has priority over all inputs.

Verification
REQ-032 enable, addr 0x1000, max 4, words 2; stream sop(type 0x0), 4 data, eop on 4th -> cmd once addr 0x1000, 4 writes, flush, complete 1 cycle, samples_out 4, truncated 0.
REQ-033 max 3, packet 6 data beats -> 3 writes, beats 4-6 dropped, truncated 1, samples_out 3.
REQ-034 master_stall high 5 cycles during cmd and mid-stream -> cmd held, ready_in low, no beat lost, write count exact.
REQ-035 non-sop beats before sop, then sop type 0xF -> leading beats dropped, packet_type_out 0xF.
REQ-036 sop arriving mid-packet after 2 data beats -> samples_out 2, truncated 1, complete pulse.
REQ-037 reset asserted during WRITING -> all outputs at reset values next cycle, no complete.
